// File: rtl/fabric_boot_pkg.sv
// Shared types and default constants for the fabric boot sequencer.
package fabric_boot_pkg;

    typedef enum logic [2:0] {
        ST_DELAY    = 3'd0,
        ST_START    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_DONE     = 3'd3,
        ST_RETRY    = 3'd4,
        ST_ERROR    = 3'd5,
        ST_EXTERNAL = 3'd6
    } boot_state_t;

    localparam int unsigned DEF_NUM_SLOTS      = 16;
    localparam int unsigned DEF_STARTUP_DELAY  = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'h0004_0000;
    localparam int unsigned DEF_MAX_RETRIES    = 2;
    localparam int unsigned CNT_W              = 32;

endpackage

// File: rtl/fabric_boot_sequencer.sv
// Sequences cold boot, warmboot reloads, timeout retries and golden-slot
// fallback; selects the bitstream source and gates fabric warmboot logic.
module fabric_boot_sequencer
    import fabric_boot_pkg::*;
#(
    parameter int unsigned NUM_SLOTS      = DEF_NUM_SLOTS,
    parameter int unsigned STARTUP_DELAY  = DEF_STARTUP_DELAY,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
    localparam int unsigned SLOT_W        = $clog2(NUM_SLOTS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mode_i,
    input  logic              warmboot_boot_i,
    input  logic [SLOT_W-1:0] warmboot_slot_i,
    input  logic              ctrl_busy_i,
    input  logic              config_busy_i,
    input  logic              config_configured_i,
    output logic              ctrl_start_o,
    output logic [SLOT_W-1:0] ctrl_slot_o,
    output logic              src_sel_o,
    output logic              warmboot_reset_o,
    output logic [SLOT_W-1:0] active_slot_o,
    output logic              boot_error_o
);

    localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    boot_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RTY_W-1:0]  rcnt_q, rcnt_d;
    logic [SLOT_W-1:0] slot_d;
    logic [SLOT_W-1:0] active_d;
    logic              seen_q, seen_d;
    logic              wb_q;
    logic              wb_edge;
    logic              load_ok;
    logic              start_d;
    logic              wbr_d;
    logic              err_d;

    // Warmboot rising edge against the registered copy; load completion qualifier.
    assign wb_edge = warmboot_boot_i & ~wb_q;
    assign load_ok = ~ctrl_busy_i & ~config_busy_i & config_configured_i & seen_q;

    // State register; mode_i picks the entry state while reset is held.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= mode_i ? ST_EXTERNAL : ST_DELAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DELAY:    if (cnt_q == CNT_W'(STARTUP_DELAY - 1)) state_d = ST_START;
            ST_START:    state_d = ST_LOAD;
            ST_LOAD: begin
                if (load_ok)                                  state_d = ST_DONE;
                else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES))     state_d = ST_RETRY;
            end
            ST_RETRY: begin
                if ((rcnt_q < RTY_W'(MAX_RETRIES)) || (ctrl_slot_o != '0)) state_d = ST_START;
                else                                                       state_d = ST_ERROR;
            end
            ST_DONE:     if (wb_edge) state_d = ST_START;
            ST_ERROR:    state_d = ST_ERROR;
            ST_EXTERNAL: state_d = ST_EXTERNAL;
            default:     state_d = ST_DELAY;
        endcase
    end

    // Next values of counters, slot bookkeeping and registered outputs.
    always_comb begin
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        slot_d   = ctrl_slot_o;
        active_d = active_slot_o;
        seen_d   = seen_q;
        start_d  = 1'b0;
        err_d    = boot_error_o;
        case (state_q)
            ST_DELAY: begin
                if (state_d == ST_START) cnt_d = '0;
                else                     cnt_d = cnt_q + CNT_W'(1);
            end
            ST_START: begin
                start_d = 1'b1;
                cnt_d   = '0;
                seen_d  = 1'b0;
            end
            ST_LOAD: begin
                if (ctrl_busy_i) seen_d = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (load_ok) begin
                    active_d = ctrl_slot_o;
                    rcnt_d   = '0;
                end
            end
            ST_RETRY: begin
                if (rcnt_q < RTY_W'(MAX_RETRIES)) begin
                    rcnt_d = rcnt_q + RTY_W'(1);
                end else if (ctrl_slot_o != '0) begin
                    slot_d = '0;
                    rcnt_d = '0;
                end
            end
            ST_DONE: begin
                if (wb_edge) slot_d = warmboot_slot_i;
            end
            default: begin
            end
        endcase
        if (state_d == ST_ERROR) err_d = 1'b1;
        case (state_d)
            ST_DONE:     wbr_d = 1'b0;
            ST_EXTERNAL: wbr_d = config_busy_i;
            default:     wbr_d = 1'b1;
        endcase
    end

    // Datapath and output registers; src_sel_o only updates while in reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q            <= '0;
            rcnt_q           <= '0;
            seen_q           <= 1'b0;
            wb_q             <= 1'b0;
            ctrl_start_o     <= 1'b0;
            ctrl_slot_o      <= '0;
            active_slot_o    <= '0;
            boot_error_o     <= 1'b0;
            warmboot_reset_o <= 1'b1;
            src_sel_o        <= mode_i;
        end else begin
            cnt_q            <= cnt_d;
            rcnt_q           <= rcnt_d;
            seen_q           <= seen_d;
            wb_q             <= warmboot_boot_i;
            ctrl_start_o     <= start_d;
            ctrl_slot_o      <= slot_d;
            active_slot_o    <= active_d;
            boot_error_o     <= err_d;
            warmboot_reset_o <= wbr_d;
        end
    end

endmodule

// File: doc/fabric_boot_sequencer.md
# fabric_boot_sequencer

Sequences all fabric configuration loads inside the FPGA core: cold boot from flash slot 0, warmboot reloads requested by the fabric, timeout-driven retries and fallback to the golden slot 0. Selects the bitstream source (SPI controller or SPI receiver) for `fabric_config` and gates the fabric warmboot logic while a load is in flight. Sits between `fabric_spi_controller`, `fabric_spi_receiver`, `fabric_config` and `fabric_wrapper`. It replaces the ad-hoc startup trigger and start logic in the core.

## Interface
- `NUM_SLOTS`, 16: flash slots; `SLOT_W = $clog2(NUM_SLOTS)`.
- `STARTUP_DELAY`, 16: cycles after reset release before the cold boot starts.
- `TIMEOUT_CYCLES`, 32'h0004_0000: maximum cycles from a start pulse to completion.
- `MAX_RETRIES`, 2: extra attempts on a slot before falling back.
- `clk_i`  in  1  core clock; one clock domain.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `mode_i`  in  1  0 = self-boot via SPI controller, 1 = external host via SPI receiver.
- `warmboot_boot_i`  in  1  fabric warmboot request (level).
- `warmboot_slot_i`  in  SLOT_W  requested slot.
- `ctrl_busy_i`  in  1  SPI controller reading.
- `config_busy_i`  in  1  fabric_config busy.
- `config_configured_i`  in  1  fabric configured.
- `ctrl_start_o`  out  1  one-cycle start pulse to the SPI controller.
- `ctrl_slot_o`  out  SLOT_W  slot for the current attempt; stable from the start pulse until the next start.
- `src_sel_o`  out  1  bitstream mux select: 0 = controller, 1 = receiver.
- `warmboot_reset_o`  out  1  holds the fabric warmboot logic in reset.
- `active_slot_o`  out  SLOT_W  slot of the last successful load.
- `boot_error_o`  out  1  sticky; set when every attempt has failed.

## Operation
- `mode_i` is sampled on every reset cycle and frozen at reset release. Changes to `mode_i` outside reset are ignored.
- FSM states: DELAY, START, LOAD, DONE, RETRY, ERROR, EXTERNAL.
- Reset values:
  - FSM: DELAY, or EXTERNAL if `mode_i` = 1 during reset.
  - Outputs: `ctrl_start_o` = 0, `ctrl_slot_o` = 0, `active_slot_o` = 0, `boot_error_o` = 0, `warmboot_reset_o` = 1.
  - `src_sel_o` = the sampled `mode_i`.
  - Retry count = 0.
- DELAY: count `STARTUP_DELAY` cycles, then go to START with slot = 0.
- START: pulse `ctrl_start_o` for exactly one cycle, clear the timeout counter, go to LOAD.
- LOAD:
  - Success when `ctrl_busy_i` = 0, `config_busy_i` = 0 and `config_configured_i` = 1, with at least one cycle of `ctrl_busy_i` = 1 seen since the start pulse.
  - On success: go to DONE, set `active_slot_o` = `ctrl_slot_o`, clear the retry count.
  - If the timeout counter reaches `TIMEOUT_CYCLES`: go to RETRY.
- RETRY:
  - If retry count < `MAX_RETRIES`: increment it and go to START with the same slot.
  - Else if slot != 0: set slot = 0, clear the retry count, go to START.
  - Else: go to ERROR.
- DONE: `warmboot_reset_o` = 0. On a rising edge of `warmboot_boot_i` (edge detector on a registered copy): latch `warmboot_slot_i`, then go to START.
- ERROR: terminal until reset. `boot_error_o` = 1, `warmboot_reset_o` = 1, no start pulses.
- EXTERNAL: `src_sel_o` = 1, never pulses start.
  - `warmboot_reset_o` follows `config_busy_i`.
  - `active_slot_o` stays 0.
- `warmboot_reset_o` = 1 in every state except DONE and EXTERNAL. Warmboot requests outside DONE are dropped, not queued.
- A warmboot slot ≥ `NUM_SLOTS` cannot occur: the input is SLOT_W wide.
- Timeout counter: 32 bits, saturating. Reaching the limit is a compare, not a wrap.

## Timing
- `ctrl_start_o` rises in the cycle after START is entered: `STARTUP_DELAY`+1 cycles after the first cycle with `rst_ni` = 1.
- Warmboot latency: edge seen at cycle N → `warmboot_reset_o` rises at N+1 and `ctrl_start_o` pulses at N+2.
- Success detection is registered. DONE is entered and `active_slot_o` updates 1 cycle after the completion condition holds.
- Timeout → next start pulse takes 2 cycles (RETRY, then START).
- Reset mid-load: the FSM returns to DELAY on the next edge. The SPI controller is not aborted by this block.

## Structure
- Package `fabric_boot_pkg`: state enum `boot_state_t`, default constants for the delay, timeout and retry parameters.
- No sub-module; the edge detector and counters are inline.
- The core instantiates this block and drives the bitstream mux from `src_sel_o`.

## Test plan
- Cold boot, mode 0, `STARTUP_DELAY` = 16: start pulse with slot 0 at cycle 17. Busy held for 100 cycles, then configured → DONE, `active_slot_o` = 0, `warmboot_reset_o` = 0.
- Warmboot to slot 5 from DONE: start pulse 2 cycles after the edge with `ctrl_slot_o` = 5. After success, `active_slot_o` = 5. A second request while loading is ignored.
- Slot 7 never completes, `TIMEOUT_CYCLES` = 1000, `MAX_RETRIES` = 2: three start pulses on slot 7, then a start on slot 0. A successful slot 0 load gives `active_slot_o` = 0.
- Slot 0 never completes: after 3 attempts, `boot_error_o` = 1 and stays 1. No further start pulses, even with `warmboot_boot_i` toggling.
- Mode 1 during reset: `src_sel_o` = 1, zero start pulses over 10k cycles. Toggling `mode_i` after reset changes nothing.
- Reset asserted mid-LOAD, then released: state returns to DELAY with outputs at reset values, and the start pulse repeats after `STARTUP_DELAY`+1 cycles.
